divider_seq_restoring: RTL and testbench

DIVIDER_SEQ_RESTORING -- requirements
Module: divider_seq_restoring

---
 rtl/divider_seq_restoring.sv | 128 ++++++++++++
 tb/tb_divider_seq_restoring.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/divider_seq_restoring.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first, N-cycle latency.
// Optional macro DIVIDER_ZERO_DETECT_EN short-circuits a zero divisor straight to DONE.
module divider_seq_restoring #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   count_r;
    logic [N:0]      partial_r;
    logic [N-1:0]    dvd_r;
    logic [N-1:0]    dvs_r;

    logic [N:0]      shifted_s;
    logic [N:0]      diff_s;
    logic            qbit_s;
    logic [N-1:0]    quot_next_s;
    logic            last_s;
    logic            zero_det_s;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted_s   = {partial_r[N-1:0], dvd_r[N-1]};
        diff_s      = shifted_s;
        qbit_s      = 1'b0;
        if (shifted_s >= {1'b0, dvs_r}) begin
            diff_s = shifted_s - {1'b0, dvs_r};
            qbit_s = 1'b1;
        end else begin
            diff_s = shifted_s;
            qbit_s = 1'b0;
        end
        // dvd_r doubles as the quotient shift register as dividend bits leave it
        quot_next_s = {dvd_r[N-2:0], qbit_s};
        last_s      = (count_r == CW'(N - 1));
    end

    // Zero-divisor detection is only present when the macro is defined.
    always_comb begin
`ifdef DIVIDER_ZERO_DETECT_EN
        zero_det_s = (divisor == {N{1'b0}});
`else
        zero_det_s = 1'b0;
`endif
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            count_r     <= {CW{1'b0}};
            partial_r   <= {(N+1){1'b0}};
            dvd_r       <= {N{1'b0}};
            dvs_r       <= {N{1'b0}};
            quotient    <= {N{1'b0}};
            remainder   <= {N{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start && zero_det_s) begin
                        state_r     <= DONE;
                        done        <= 1'b1;
                        quotient    <= {N{1'b1}};
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                    end else if (start) begin
                        state_r   <= CALC;
                        busy      <= 1'b1;
                        count_r   <= {CW{1'b0}};
                        partial_r <= {(N+1){1'b0}};
                        dvd_r     <= dividend;
                        dvs_r     <= divisor;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    partial_r <= diff_s;
                    dvd_r     <= quot_next_s;
                    count_r   <= count_r + CW'(1);
                    if (last_s) begin
                        state_r     <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= quot_next_s;
                        remainder   <= diff_s[N-1:0];
                        div_by_zero <= 1'b0;
                    end else begin
                        state_r <= CALC;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_seq_restoring.sv
// Self-checking bench for divider_seq_restoring (N = 8): directed table, corner sequences, random ops.
module tb_divider_seq_restoring;

    localparam int N = 8;
`ifdef DIVIDER_ZERO_DETECT_EN
    localparam bit ZD = 1'b1;
`else
    localparam bit ZD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] dividend = 8'd0;
    logic [N-1:0] divisor = 8'd0;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    divider_seq_restoring #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue one operation; optionally fire a second start at cycle inj_k after acceptance.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int inj_k,
                          output int lat, output int bcnt, output int stamp,
                          output logic [7:0] q, output logic [7:0] r, output logic dz);
        logic busy_at_done;
        busy_at_done = 1'b0;
        q = 8'd0; r = 8'd0; dz = 1'b0; lat = -1; bcnt = 0; stamp = -1;
        dividend = a; divisor = b; start = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 40; k++) begin
            if (k == inj_k) begin
                start = 1'b1; dividend = 8'd200; divisor = 8'd3;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = k; stamp = cyc; q = quotient; r = remainder; dz = div_by_zero;
                busy_at_done = busy;
                break;
            end
            if (busy) bcnt++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_low_at_done", int'(busy_at_done), 0);
        @(negedge clk);
        chk("done_single_cycle", int'(done), 0);
    endtask

    // Expected results straight from the arithmetic definition.
    task automatic check_op(input string tag, input logic [7:0] a, input logic [7:0] b, input int inj_k);
        int lat, bcnt, stamp, exp_lat, exp_busy;
        logic [7:0] q, r, eq, er;
        logic dz, edz;
        if (b == 8'd0) begin
            eq = 8'd255; er = a; edz = ZD;
        end else begin
            eq = a / b; er = a % b; edz = 1'b0;
        end
        exp_lat  = (b == 8'd0 && ZD) ? 1 : N + 1;
        exp_busy = (b == 8'd0 && ZD) ? 0 : N;
        run_op(a, b, inj_k, lat, bcnt, stamp, q, r, dz);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_busy_cycles"}, bcnt, exp_busy);
        chk({tag, "_quotient"}, int'(q), int'(eq));
        chk({tag, "_remainder"}, int'(r), int'(er));
        chk({tag, "_div_by_zero"}, int'(dz), int'(edz));
    endtask

    initial begin
        int lat, bcnt, s1, s2;
        logic [7:0] q, r;
        logic dz;
        bit seen;

        vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0};
        vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
        vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
        vecs[3] = '{8'd0,   8'd3,   8'd0,   8'd0,   1'b0};
        vecs[4] = '{8'd77,  8'd0,   8'd255, 8'd77,  ZD};
        vecs[5] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
        vecs[6] = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0};
        vecs[7] = '{8'd200, 8'd3,   8'd66,  8'd2,   1'b0};

        // Reset state, with a start held high to confirm reset wins.
        start = 1'b1; dividend = 8'd9; divisor = 8'd2;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_dbz", int'(div_by_zero), 0);
        start = 1'b0; rst = 1'b0;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, 0, lat, bcnt, s1, q, r, dz);
            chk($sformatf("vec%0d_latency", i), lat, (vecs[i].b == 8'd0 && ZD) ? 1 : N + 1);
            chk($sformatf("vec%0d_quotient", i), int'(q), int'(vecs[i].q));
            chk($sformatf("vec%0d_remainder", i), int'(r), int'(vecs[i].r));
            chk($sformatf("vec%0d_div_by_zero", i), int'(dz), int'(vecs[i].dz));
        end

        // Start pulsed mid-CALC with new operands must be ignored.
        check_op("ignore_mid_start", 8'd100, 8'd7, 3);

        // Results hold after done.
        repeat (3) @(negedge clk);
        chk("hold_quotient", int'(quotient), 14);
        chk("hold_remainder", int'(remainder), 2);

        // Reset in the 4th CALC cycle abandons the operation.
        dividend = 8'd100; divisor = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_quotient", int'(quotient), 0);
        chk("midrst_remainder", int'(remainder), 0);
        chk("midrst_dbz", int'(div_by_zero), 0);
        seen = 1'b0;
        repeat (12) begin
            if (done) seen = 1'b1;
            @(negedge clk);
        end
        chk("midrst_no_done", int'(seen), 0);
        check_op("after_rst_9_2", 8'd9, 8'd2, 0);

        // Back-to-back operations.
        run_op(8'd50, 8'd5, 0, lat, bcnt, s1, q, r, dz);
        chk("b2b1_quotient", int'(q), 10);
        chk("b2b1_remainder", int'(r), 0);
        run_op(8'd51, 8'd5, 0, lat, bcnt, s2, q, r, dz);
        chk("b2b2_quotient", int'(q), 10);
        chk("b2b2_remainder", int'(r), 1);
        chk("b2b_done_spacing", s2 - s1, N + 2);

        // Random operations, including occasional zero divisors.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom_range(0, 255));
            b = (i % 8 == 7) ? 8'd0 : 8'($urandom_range(0, 255));
            check_op($sformatf("rand%0d", i), a, b, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
